// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line input plus the received-byte outputs.
// The receiver uses the master modport and the consumer/driver uses the slave modport.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    modport master (
        input  rx,
        output rx_data,
        output rx_valid,
        output rx_busy,
        output frame_err
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised line, falling-edge start detection,
// mid-bit sampling and one-cycle valid / framing-error pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t        state_reg;
    logic [BW-1:0] baud_reg;
    logic [2:0]    bit_reg;
    logic [7:0]    shift_reg;
    logic [7:0]    rx_data_reg;
    logic          rx_valid_reg;
    logic          rx_busy_reg;
    logic          frame_err_reg;
    logic          sync1_reg;
    logic          rx_s_reg;
    logic          rx_prev_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            baud_reg      <= '0;
            bit_reg       <= '0;
            shift_reg     <= '0;
            rx_data_reg   <= 8'h00;
            rx_valid_reg  <= 1'b0;
            rx_busy_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            sync1_reg     <= 1'b1;
            rx_s_reg      <= 1'b1;
            rx_prev_reg   <= 1'b1;
        end else begin
            sync1_reg     <= bus.rx;
            rx_s_reg      <= sync1_reg;
            rx_prev_reg   <= rx_s_reg;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // Only a genuine 1->0 transition starts a frame; a held-low line never does.
                    if (rx_prev_reg && !rx_s_reg) begin
                        state_reg   <= START_BIT;
                        baud_reg    <= '0;
                        bit_reg     <= '0;
                        rx_busy_reg <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (baud_reg == HALF_LAST) begin
                        baud_reg <= '0;
                        if (!rx_s_reg) begin
                            state_reg <= DATA_BITS;
                        end else begin
                            state_reg   <= IDLE;
                            rx_busy_reg <= 1'b0;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (baud_reg == FULL_LAST) begin
                        baud_reg  <= '0;
                        shift_reg <= {rx_s_reg, shift_reg[7:1]};
                        if (bit_reg == 3'd7) begin
                            state_reg <= STOP_BIT;
                        end else begin
                            bit_reg <= bit_reg + 1'b1;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (baud_reg == FULL_LAST) begin
                        baud_reg    <= '0;
                        state_reg   <= IDLE;
                        rx_busy_reg <= 1'b0;
                        if (rx_s_reg) begin
                            rx_data_reg  <= shift_reg;
                            rx_valid_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    baud_reg    <= '0;
                    rx_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = rx_data_reg;
    assign bus.rx_valid  = rx_valid_reg;
    assign bus.rx_busy   = rx_busy_reg;
    assign bus.frame_err = frame_err_reg;
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit; legal range is even values from 4 to 8190.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (reset=0 resets).
REQ-004 SHALL have port rx, input, 1, serial line: idle high, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-005 SHALL have port rx_data, output, 8, the last correctly framed byte.
REQ-006 SHALL have port rx_valid, output, 1, one-cycle pulse when rx_data is updated.
REQ-007 SHALL have port rx_busy, output, 1, high while the state is not IDLE.
REQ-008 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit samples 0.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer to give rx_s, plus a registered copy rx_prev; both flops and rx_prev reset to 1.
REQ-010 SHALL implement the states IDLE, START_BIT, DATA_BITS and STOP_BIT, using a bit counter (0..7) and a baud counter wide enough for CLKS_PER_BIT-1.
REQ-011 IDLE: SHALL detect a start edge only on rx_prev=1 and rx_s=0; on that edge (cycle t0), enter START_BIT with baud counter=0 and bit counter=0.
REQ-012 IDLE: SHALL NOT treat a line held low as a new start edge; a new frame requires rx_s to return to 1 first.
REQ-013 START_BIT: SHALL sample rx_s at t0+CLKS_PER_BIT/2 (mid-bit).
REQ-014 START_BIT: if that sample is 0, SHALL enter DATA_BITS with baud counter cleared.
REQ-015 START_BIT: if that sample is 1, SHALL treat it as a false start and return to IDLE with no rx_valid and no frame_err.
REQ-016 DATA_BITS: SHALL sample bit k (k=0..7) at t0+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
REQ-017 DATA_BITS: SHALL shift each sample into a shift register, LSB first; after bit 7, SHALL enter STOP_BIT.
REQ-018 STOP_BIT: SHALL sample rx_s at t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT, then return to IDLE on the same edge.
REQ-019 STOP_BIT: if the stop sample is 1, SHALL load rx_data from the shift register and pulse rx_valid high for exactly one cycle.
REQ-020 STOP_BIT: if the stop sample is 0, SHALL pulse frame_err for one cycle and leave rx_data unchanged.
REQ-021 rx_valid and frame_err SHALL never be high in the same cycle, and SHALL never be high for more than one cycle per frame.
REQ-022 Back-to-back frames: a start edge arriving on or after the stop-sample cycle SHALL be accepted with no lost frame.
REQ-023 rx_data SHALL hold its value until the next valid frame; there is no consumer handshake and no overrun flag.
REQ-024 rx_busy SHALL be registered, going high in cycle t0+1 and low in the cycle after the stop sample or false start.
REQ-025 Counter updates SHALL have a single priority: a state transition clears the baud counter, and the counters never wrap inside a bit period.

Reset
REQ-026 While reset=0, SHALL force state=IDLE, counters=0, shift register=0, rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0, and sync flops/rx_prev=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse.
REQ-028 After reset release, a frame SHALL be received only after a fresh high-to-low edge on rx_s.

Verification
REQ-029 With CLKS_PER_BIT=16, send byte 8'hA5 correctly framed: rx_valid pulses once exactly 16/2+9*16=152 cycles after t0; rx_data=8'hA5; frame_err=0.
REQ-030 Send 8'h00 then 8'hFF back-to-back with zero idle gap: two rx_valid pulses, with rx_data=8'h00 then 8'hFF.
REQ-031 Drive a 0 pulse on rx lasting 4 cycles: state returns to IDLE, rx_busy drops, and rx_valid and frame_err stay 0.
REQ-032 Send 8'h3C with stop bit=0, then hold rx low for 40 bit periods: frame_err pulses once, rx_data keeps its previous value, and no further frame is received until rx goes high and a new start edge occurs.
REQ-033 Assert reset=0 during data bit 4 of a frame, then release and send 8'h5A: no pulse for the aborted frame; rx_data=8'h5A with one rx_valid.
REQ-034 With CLKS_PER_BIT=4, send 8'h81: rx_valid is seen 38 cycles after t0 and rx_data=8'h81.
